// File: rtl/x_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : x_sequencer
// Description : Host command sequencer for x_driver. Forwards raw opcodes and
//               expands a one-byte burst command into paced capture/unload runs.
// Revision    : 1.0
// ============================================================================
module x_sequencer #(
    parameter logic [7:0] GAP_RESET = 8'd16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    input  logic [7:0] i_cmd_data,
    output logic       o_drv_valid,
    output logic [7:0] o_drv_data,
    input  logic       i_drv_tx_valid,
    input  logic       i_drv_tx_accept,
    output logic       o_busy,
    output logic       o_drop
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_CAPT = 3'd2,
        ST_UNLD = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    localparam logic [7:0] c_OP_CAPTURE = 8'h02;
    localparam logic [7:0] c_OP_UNLOAD  = 8'h01;
    localparam logic [7:0] c_ABORT      = 8'hFF;

    state_t      r_state;
    logic [7:0]  r_gap_q;
    logic [7:0]  r_gap_cnt;
    logic [4:0]  r_sample_cnt;
    logic [2:0]  r_byte_cnt;

    logic [3:0]  w_op;
    logic [3:0]  w_arg;
    logic        w_handshake;
    logic        w_abort;

    assign w_op        = i_cmd_data[3:0];
    assign w_arg       = i_cmd_data[7:4];
    assign w_handshake = i_drv_tx_valid & i_drv_tx_accept;
    assign w_abort     = i_cmd_valid && (i_cmd_data == c_ABORT);

    // Driver strobes are registered on entry to CAPT/UNLD so they are visible
    // during those states.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_gap_q      <= GAP_RESET;
            r_gap_cnt    <= 8'd0;
            r_sample_cnt <= 5'd0;
            r_byte_cnt   <= 3'd0;
            o_drv_valid  <= 1'b0;
            o_drv_data   <= 8'd0;
            o_busy       <= 1'b0;
            o_drop       <= 1'b0;
        end else begin
            o_drv_valid <= 1'b0;
            o_drop      <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (i_cmd_valid) begin
                    case (w_op)
                        4'h0, 4'h1, 4'h2: begin
                            o_drv_valid <= 1'b1;
                            o_drv_data  <= i_cmd_data;
                        end
                        4'h3: begin
                            r_sample_cnt <= {(w_arg == 4'd0), w_arg};
                            r_gap_cnt    <= r_gap_q;
                            r_state      <= ST_GAP;
                            o_busy       <= 1'b1;
                        end
                        4'h4: r_gap_q <= {w_arg, 4'h0};
                        default: ;
                    endcase
                end
            end else if (w_abort) begin
                // Any TX byte already pending in x_driver is left to drain.
                r_state <= ST_IDLE;
                o_busy  <= 1'b0;
            end else begin
                if (i_cmd_valid) begin
                    o_drop <= 1'b1;
                end
                case (r_state)
                    ST_GAP: begin
                        if (r_gap_cnt == 8'd0) begin
                            r_state     <= ST_CAPT;
                            o_drv_valid <= 1'b1;
                            o_drv_data  <= c_OP_CAPTURE;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - 8'd1;
                        end
                    end
                    ST_CAPT: begin
                        r_byte_cnt  <= 3'd4;
                        r_state     <= ST_UNLD;
                        o_drv_valid <= 1'b1;
                        o_drv_data  <= c_OP_UNLOAD;
                    end
                    ST_UNLD: r_state <= ST_WAIT;
                    ST_WAIT: begin
                        if (w_handshake) begin
                            r_byte_cnt <= r_byte_cnt - 3'd1;
                            if (r_byte_cnt > 3'd1) begin
                                r_state     <= ST_UNLD;
                                o_drv_valid <= 1'b1;
                                o_drv_data  <= c_OP_UNLOAD;
                            end else if (r_sample_cnt == 5'd1) begin
                                r_sample_cnt <= 5'd0;
                                r_state      <= ST_IDLE;
                                o_busy       <= 1'b0;
                            end else begin
                                r_sample_cnt <= r_sample_cnt - 5'd1;
                                r_gap_cnt    <= r_gap_q;
                                r_state      <= ST_GAP;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
